// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes on data-memory wait, flushes on taken branch,
// inserts a one-cycle bubble on load-use, and keeps stall/timeout statistics.
module hazard_ctrl #(
    parameter int STALL_CNT_W = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   redirect,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   mem_timeout
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0]            TIMEOUT_VAL = 16'(MEM_TIMEOUT);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX   = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] STALL_ONE   = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic                     redirect_pend_q, redirect_pend_d;
    logic [15:0]              wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic                     mem_timeout_q, mem_timeout_d;

    logic mem_stall;
    logic load_use;
    logic br;

    always_comb begin
        mem_stall = mem_req && !mem_ready;
        load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
        br        = ex_branch_taken || redirect_pend_q;
    end

    // Enables are combinational so the pipeline reacts in the same cycle as the hazard.
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        redirect    = 1'b0;
        if (rst || mem_stall) begin
            pc_en = 1'b0;
        end else if (br) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            redirect    = 1'b1;
        end else if (load_use) begin
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
        end
    end

    always_comb begin
        state_d         = mem_stall ? MEM_WAIT : RUN;
        // A branch resolved during a freeze is parked until the pipeline can move again.
        redirect_pend_d = mem_stall ? (redirect_pend_q || ex_branch_taken) : 1'b0;

        wait_cnt_d = wait_cnt_q;
        if (state_q == RUN) begin
            if (mem_stall) begin
                wait_cnt_d = 16'd0;
            end
        end else if (!mem_ready && (wait_cnt_q < TIMEOUT_VAL)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end

        mem_timeout_d = mem_timeout_q || (wait_cnt_d == TIMEOUT_VAL);

        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != STALL_MAX)) begin
            stall_cycles_d = stall_cycles_q + STALL_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            redirect_pend_q <= 1'b0;
            wait_cnt_q      <= 16'd0;
            stall_cycles_q  <= '0;
            mem_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
            wait_cnt_q      <= wait_cnt_d;
            stall_cycles_q  <= stall_cycles_d;
            mem_timeout_q   <= mem_timeout_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_hazard_ctrl;
    localparam int SW = 6;
    localparam int MT = 4;
    localparam int SMAX = (1 << SW) - 1;
    localparam logic [7:0] FREEZE = 8'b00000_000;
    localparam logic [7:0] BRANCH = 8'b11111_111;
    localparam logic [7:0] BUBBLE = 8'b00111_010;
    localparam logic [7:0] NORMAL = 8'b11111_000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_branch_taken = 0;
    logic mem_req = 0, mem_ready = 0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, redirect, mem_timeout;
    logic [SW-1:0] stall_cycles;
    logic [7:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    bit m_pend, m_in_wait, m_to;
    int m_wait, m_stall;

    hazard_ctrl #(.STALL_CNT_W(SW), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .redirect(redirect),
        .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
    );

    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, redirect};

    always #5 clk = ~clk;

    function automatic logic [7:0] model_outs();
        bit ms = mem_req && !mem_ready;
        bit lu = ex_mem_read && (ex_rd != 0) &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        bit br = ex_branch_taken || m_pend;
        if (rst) return FREEZE;
        if (ms)  return FREEZE;
        if (br)  return BRANCH;
        if (lu)  return BUBBLE;
        return NORMAL;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_in_wait = 0; m_to = 0; m_wait = 0; m_stall = 0;
    endtask

    task automatic model_step();
        logic [7:0] o;
        bit ms;
        if (rst) begin
            model_reset();
        end else begin
            o  = model_outs();
            ms = mem_req && !mem_ready;
            if (!o[7] && m_stall < SMAX) m_stall++;
            if (!m_in_wait) begin
                if (ms) m_wait = 0;
            end else if (!mem_ready && m_wait < MT) begin
                m_wait++;
            end
            if (m_wait == MT) m_to = 1;
            m_pend    = ms ? (m_pend || ex_branch_taken) : 0;
            m_in_wait = ms;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (outs !== FREEZE) begin n_fail++; $display("FAIL reset_outs: got %b want %b", outs, FREEZE); end
        n_checks++;
        if (stall_cycles !== '0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
        n_checks++;
        if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
        rst = 0;
        tick();
    endtask

    task automatic test_load_use();
        int e;
        idle_inputs();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        @(negedge clk);
        n_checks++;
        if (outs !== BUBBLE) begin n_fail++; $display("FAIL load_use_outs: got %b want %b", outs, BUBBLE); end
        e = m_stall + 1;
        tick();
        n_checks++;
        if (stall_cycles !== SW'(e)) begin n_fail++; $display("FAIL load_use_stall: got %0d want %0d", stall_cycles, e); end
    endtask

    task automatic test_load_use_x0();
        int e;
        idle_inputs();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
        @(negedge clk);
        n_checks++;
        if (outs !== NORMAL) begin n_fail++; $display("FAIL x0_outs: got %b want %b", outs, NORMAL); end
        e = m_stall;
        tick();
        n_checks++;
        if (stall_cycles !== SW'(e)) begin n_fail++; $display("FAIL x0_stall: got %0d want %0d", stall_cycles, e); end
        idle_inputs();
        ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
        @(negedge clk);
        n_checks++;
        if (outs !== BUBBLE) begin n_fail++; $display("FAIL rs2_outs: got %b want %b", outs, BUBBLE); end
        tick();
    endtask

    task automatic test_branch_over_load_use();
        idle_inputs();
        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_uses_rs1 = 1; ex_branch_taken = 1;
        @(negedge clk);
        n_checks++;
        if (outs !== BRANCH) begin n_fail++; $display("FAIL br_lu_outs: got %b want %b", outs, BRANCH); end
        tick();
        idle_inputs();
    endtask

    task automatic test_freeze_branch();
        int e;
        idle_inputs();
        e = m_stall + 3;
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== FREEZE) begin n_fail++; $display("FAIL freeze_outs[%0d]: got %b want %b", k, outs, FREEZE); end
            tick();
            ex_branch_taken = 0;
        end
        mem_ready = 1;
        @(negedge clk);
        n_checks++;
        if (outs !== BRANCH) begin n_fail++; $display("FAIL release_outs: got %b want %b", outs, BRANCH); end
        tick();
        n_checks++;
        if (stall_cycles !== SW'(e)) begin n_fail++; $display("FAIL freeze_stall: got %0d want %0d", stall_cycles, e); end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (outs !== NORMAL) begin n_fail++; $display("FAIL pend_cleared: got %b want %b", outs, NORMAL); end
        tick();
    endtask

    task automatic test_timeout();
        idle_inputs();
        mem_req = 1; mem_ready = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if (mem_timeout !== (k >= MT + 1)) begin
                n_fail++; $display("FAIL timeout_edge[%0d]: got %b want %b", k, mem_timeout, (k >= MT + 1));
            end
        end
        mem_ready = 1;
        tick();
        idle_inputs();
        repeat (3) tick();
        n_checks++;
        if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout); end
        @(negedge clk);
        rst = 1; model_reset();
        #1;
        n_checks++;
        if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_rst: got %b want 0", mem_timeout); end
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset_mid_freeze();
        idle_inputs();
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        tick();
        ex_branch_taken = 0;
        tick();
        @(negedge clk);
        rst = 1; model_reset();
        #1;
        n_checks++;
        if (outs !== FREEZE) begin n_fail++; $display("FAIL rst_mid_outs: got %b want %b", outs, FREEZE); end
        n_checks++;
        if (stall_cycles !== '0) begin n_fail++; $display("FAIL rst_mid_stall: got %0d want 0", stall_cycles); end
        tick();
        rst = 0;
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (outs !== NORMAL) begin n_fail++; $display("FAIL rst_no_redirect: got %b want %b", outs, NORMAL); end
        tick();
    endtask

    task automatic test_stall_saturate();
        idle_inputs();
        mem_req = 1; mem_ready = 0;
        repeat (10) tick();
        n_checks++;
        if (stall_cycles !== SW'(10)) begin n_fail++; $display("FAIL stall_count: got %0d want 10", stall_cycles); end
        repeat (60) tick();
        n_checks++;
        if (stall_cycles !== SW'(SMAX)) begin n_fail++; $display("FAIL stall_sat: got %0d want %0d", stall_cycles, SMAX); end
        mem_ready = 1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [7:0] e;
        rst = 1; model_reset();
        tick();
        rst = 0;
        for (int i = 0; i < 500; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            if (rst) model_reset();
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = $urandom_range(0, 1);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            ex_mem_read     = $urandom_range(0, 1);
            ex_rd           = 5'($urandom_range(0, 3));
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_uses_rs1     = $urandom_range(0, 1);
            id_uses_rs2     = $urandom_range(0, 1);
            @(negedge clk);
            e = model_outs();
            n_checks++;
            if (outs !== e) begin n_fail++; $display("FAIL rand_outs[%0d]: got %b want %b", i, outs, e); end
            tick();
            n_checks++;
            if (stall_cycles !== SW'(m_stall)) begin n_fail++; $display("FAIL rand_stall[%0d]: got %0d want %0d", i, stall_cycles, m_stall); end
            n_checks++;
            if (mem_timeout !== m_to) begin n_fail++; $display("FAIL rand_timeout[%0d]: got %b want %b", i, mem_timeout, m_to); end
        end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_load_use_x0();
        test_branch_over_load_use();
        test_freeze_branch();
        test_timeout();
        test_reset_mid_freeze();
        test_stall_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter STALL_CNT_W, default 32, width of the stall-cycle counter.
REQ-002 SHALL provide parameter MEM_TIMEOUT, default 255, number of MEM_WAIT cycles before the timeout flag sets (range 1..65535).
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-006 SHALL have ports id_uses_rs1, id_uses_rs2  input  1 each  ID instruction actually reads rs1 / rs2.
REQ-007 SHALL have port ex_rd  input  5  destination index of the instruction in EX.
REQ-008 SHALL have port ex_mem_read  input  1  EX instruction is a load.
REQ-009 SHALL have port ex_branch_taken  input  1  single-cycle pulse: taken branch/jump resolved in EX.
REQ-010 SHALL have ports mem_req and mem_ready  input  1 each  MEM-stage data access request / data memory completion.
REQ-011 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  pipeline register load enables.
REQ-012 SHALL have ports if_id_flush, id_ex_flush  output  1 each  insert bubble (NOP) into IF/ID / ID/EX on the next edge.
REQ-013 SHALL have port redirect  output  1  PC mux selects branch target this cycle.
REQ-014 SHALL have port stall_cycles  output  STALL_CNT_W  count of cycles in which pc_en was 0 outside reset.
REQ-015 SHALL have port mem_timeout  output  1  sticky flag: memory wait reached MEM_TIMEOUT.

Function
REQ-016 SHALL implement an FSM with states RUN and MEM_WAIT, plus a redirect_pend register and a wait counter (16 bits).
REQ-017 SHALL define mem_stall = mem_req && !mem_ready; load_use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)); br = ex_branch_taken || redirect_pend.
REQ-018 SHALL apply priority mem_stall > br > load_use > normal, evaluated combinationally in the current cycle and valid in both states.
REQ-019 On mem_stall: all five enables 0, both flushes 0, redirect 0 (full freeze).
REQ-020 On br without mem_stall: all enables 1, if_id_flush=1, id_ex_flush=1, redirect=1; br overrides load_use, because the ID instruction is wrong-path.
REQ-021 On load_use alone: pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en/ex_mem_en/mem_wb_en=1, redirect=0; this is a one-cycle bubble that the forwarding unit then resolves from MEM/WB.
REQ-022 On normal: all enables 1, flushes 0, redirect 0.
REQ-023 Transitions: RUN->MEM_WAIT when mem_stall; MEM_WAIT->RUN in the cycle after mem_ready=1 (the release cycle advances the pipeline per REQ-020..022); otherwise hold.
REQ-024 redirect_pend SHALL set when ex_branch_taken && mem_stall, and clear on the edge of the cycle in which REQ-020 fires; a redirect is never lost during a freeze.
REQ-025 The wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle with mem_ready=0, saturating at MEM_TIMEOUT.
REQ-026 mem_timeout SHALL set when the wait counter equals MEM_TIMEOUT and remain set until rst; the freeze continues regardless.
REQ-027 stall_cycles SHALL increment by 1 on each edge where pc_en==0 and rst==0, and saturate at all-ones.
REQ-028 Registered values SHALL be written only on rising clk.

Reset
REQ-029 While rst=1 (asynchronously): state=RUN, redirect_pend=0, wait counter=0, stall_cycles=0, mem_timeout=0, all enables 0, flushes 0, redirect 0.
REQ-030 Reset mid-MEM_WAIT or with redirect_pend=1 SHALL discard both; after rst deasserts, behaviour follows REQ-018 from RUN.

Verification
REQ-031 ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, stall_cycles +1.
REQ-032 Same as REQ-031 but ex_rd=0 -> no stall, all enables 1, flushes 0.
REQ-033 load_use and ex_branch_taken together -> redirect=1, both flushes 1, pc_en=1.
REQ-034 mem_req=1, mem_ready=0 for 3 cycles, ex_branch_taken pulsed in the 1st of them, mem_ready=1 in the 4th -> enables 0 for 3 cycles; 4th cycle enables 1, redirect=1, both flushes 1; redirect_pend=0 afterwards.
REQ-035 MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout=1 after the 4th MEM_WAIT cycle and stays 1 after mem_ready rises; rst clears it.
REQ-036 rst asserted mid-freeze with redirect_pend=1 -> all state and outputs at reset values immediately; after release, no redirect issued.
